// File: rtl/csla_sub_pipe.sv
// csla_sub_pipe: two-stage pipelined 32-bit subtractor (d = x - y) on a 3/4/5/6/7/7 carry-select/BEC
// partition. Stage 1 resolves bits 17:0 and keeps both candidates of the two upper blocks. Stage 2
// selects those candidates and produces the flags. Both ends use a valid/ready stream.
module csla_sub_pipe #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             borrow,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned B4_W = 7;
    localparam int unsigned B5_W = 7;
    localparam int unsigned LO_W = 18;

    // Stage-1 payload: resolved low bits plus both candidates of blocks 4 and 5
    typedef struct packed {
        logic [LO_W-1:0] lo;
        logic            c18;
        logic [B4_W-1:0] b4_s0;
        logic            b4_c0;
        logic [B4_W-1:0] b4_s1;
        logic            b4_c1;
        logic [B5_W-1:0] b5_s0;
        logic            b5_c0;
        logic [B5_W-1:0] b5_s1;
        logic            b5_c1;
        logic            x31;
        logic            y31;
    } s1_t;

    // Block boundaries of the fixed partition
    function automatic int unsigned blk_lsb(input int unsigned b);
        case (b)
            0:       return 0;
            1:       return 3;
            2:       return 7;
            3:       return 12;
            4:       return 18;
            default: return 25;
        endcase
    endfunction

    function automatic int unsigned blk_w(input int unsigned b);
        case (b)
            0:       return 3;
            1:       return 4;
            2:       return 5;
            3:       return 6;
            default: return 7;
        endcase
    endfunction

    logic [31:0] y_inv;
    logic [31:3] cand_s0;
    logic [31:3] cand_s1;
    logic [5:1]  cand_c0;
    logic [5:1]  cand_c1;
    logic [2:0]  b0_sum;
    logic        b0_carry;
    logic        c3;
    logic        c7;
    logic        c12;
    logic        c18;
    logic [LO_W-1:0] lo_sum;
    s1_t         s1_new;

    logic        s1_adv;
    logic        s2_adv;
    logic        s1_valid_q;
    logic        s1_valid_d;
    s1_t         s1_q;
    s1_t         s1_d;
    logic        s2_valid_q;
    logic        s2_valid_d;
    logic [31:0] d_q;
    logic [31:0] d_d;
    logic        borrow_q;
    logic        borrow_d;
    logic        ovf_q;
    logic        ovf_d;
    logic        zero_q;
    logic        zero_d;

    logic [B4_W-1:0] b4_sel;
    logic            c25;
    logic [B5_W-1:0] b5_sel;
    logic            c32;
    logic [31:0]     d_new;

    assign y_inv = ~y;

    // Block 0: ripple add with the +1 of the two's complement as carry-in
    always_comb begin
        b0_sum   = '0;
        b0_carry = 1'b1;
        for (int unsigned i = 0; i < blk_w(0); i++) begin
            b0_sum[i] = x[i] ^ y_inv[i] ^ b0_carry;
            b0_carry  = (x[i] & y_inv[i]) | (b0_carry & (x[i] ^ y_inv[i]));
        end
        c3 = b0_carry;
    end

    // Blocks 1-5: carry-0 ripple sum and its BEC (+1) as the carry-1 candidate
    for (genvar g = 1; g < 6; g++) begin : g_blk
        localparam int unsigned LSB = blk_lsb(g);
        localparam int unsigned BW  = blk_w(g);

        logic [BW-1:0] sum0;
        logic [BW-1:0] sum1;
        logic          carry;
        logic          run;
        logic          cout0;
        logic          cout1;

        // Candidate generation for one block
        always_comb begin
            sum0  = '0;
            sum1  = '0;
            carry = 1'b0;
            run   = 1'b1;
            for (int unsigned i = 0; i < BW; i++) begin
                sum0[i] = x[LSB+i] ^ y_inv[LSB+i] ^ carry;
                carry   = (x[LSB+i] & y_inv[LSB+i]) | (carry & (x[LSB+i] ^ y_inv[LSB+i]));
            end
            cout0 = carry;
            for (int unsigned i = 0; i < BW; i++) begin
                sum1[i] = sum0[i] ^ run;
                run     = run & sum0[i];
            end
            // {cout,sum}+1 carries into cout only when the whole sum was all ones
            cout1 = cout0 ^ run;
        end

        assign cand_s0[LSB +: BW] = sum0;
        assign cand_s1[LSB +: BW] = sum1;
        assign cand_c0[g]         = cout0;
        assign cand_c1[g]         = cout1;
    end

    // Stage-1 select chain over blocks 1-3 and payload assembly
    always_comb begin
        lo_sum        = '0;
        lo_sum[2:0]   = b0_sum;
        lo_sum[6:3]   = c3  ? cand_s1[6:3]   : cand_s0[6:3];
        c7            = c3  ? cand_c1[1]     : cand_c0[1];
        lo_sum[11:7]  = c7  ? cand_s1[11:7]  : cand_s0[11:7];
        c12           = c7  ? cand_c1[2]     : cand_c0[2];
        lo_sum[17:12] = c12 ? cand_s1[17:12] : cand_s0[17:12];
        c18           = c12 ? cand_c1[3]     : cand_c0[3];

        s1_new       = '0;
        s1_new.lo    = lo_sum;
        s1_new.c18   = c18;
        s1_new.b4_s0 = cand_s0[24:18];
        s1_new.b4_c0 = cand_c0[4];
        s1_new.b4_s1 = cand_s1[24:18];
        s1_new.b4_c1 = cand_c1[4];
        s1_new.b5_s0 = cand_s0[31:25];
        s1_new.b5_c0 = cand_c0[5];
        s1_new.b5_s1 = cand_s1[31:25];
        s1_new.b5_c1 = cand_c1[5];
        s1_new.x31   = x[31];
        s1_new.y31   = y[31];
    end

    // Pipeline advance conditions; in_ready never looks at the operands
    always_comb begin
        s2_adv   = !s2_valid_q | out_ready;
        s1_adv   = !s1_valid_q | s2_adv;
        in_ready = s1_adv;
    end

    // Stage-1 next state: load on accept, valid follows in_valid whenever the stage can move
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_d = s1_new;
            end
        end
    end

    // Stage-2 next state: final block selects, flags, and hold under backpressure
    always_comb begin
        b4_sel = s1_q.c18 ? s1_q.b4_s1 : s1_q.b4_s0;
        c25    = s1_q.c18 ? s1_q.b4_c1 : s1_q.b4_c0;
        b5_sel = c25 ? s1_q.b5_s1 : s1_q.b5_s0;
        c32    = c25 ? s1_q.b5_c1 : s1_q.b5_c0;
        d_new  = {b5_sel, b4_sel, s1_q.lo};

        s2_valid_d = s2_valid_q;
        d_d        = d_q;
        borrow_d   = borrow_q;
        ovf_d      = ovf_q;
        zero_d     = zero_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                d_d      = d_new;
                borrow_d = ~c32;
                ovf_d    = (s1_q.x31 ^ s1_q.y31) & (s1_q.x31 ^ d_new[31]);
                zero_d   = (d_new == 32'd0);
            end
        end
    end

    // Pipeline registers; reset drops anything in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_valid_q <= 1'b0;
            d_q        <= '0;
            borrow_q   <= 1'b0;
            ovf_q      <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_q       <= s1_d;
            s2_valid_q <= s2_valid_d;
            d_q        <= d_d;
            borrow_q   <= borrow_d;
            ovf_q      <= ovf_d;
            zero_q     <= zero_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign d         = WIDTH'(d_q);
    assign borrow    = borrow_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_csla_sub_pipe.sv
// Bench for csla_sub_pipe: directed corner cases plus a randomized valid/ready stream,
// all scored against an arithmetic reference model and an in-order expectation queue.
module tb_csla_sub_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x;
    logic [31:0] y;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] d;
    logic        borrow;
    logic        ovf;
    logic        zero;

    int total = 0;
    int bad   = 0;
    int n_in  = 0;
    int n_out = 0;
    logic [34:0] exp_q[$];

    always #5 clk = ~clk;

    csla_sub_pipe #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .borrow    (borrow),
        .ovf       (ovf),
        .zero      (zero)
    );

    // Single comparison point
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Reference: {d, borrow, ovf, zero} from plain integer arithmetic
    function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        bo;
        logic        ov;
        longint      sd;
        r  = a - b;
        bo = (a < b);
        sd = longint'($signed(a)) - longint'($signed(b));
        ov = (sd > 64'sd2147483647) || (sd < -(64'sd2147483648));
        return {r, bo, ov, (r == 32'd0)};
    endfunction

    // Scores the transfers that the coming rising edge will perform
    task automatic monitor();
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("extra_out", 64'(1), 64'(0));
            end else begin
                chk("out", 64'({d, borrow, ovf, zero}), 64'(exp_q.pop_front()));
                n_out++;
            end
        end
        if (rst_n && in_valid && in_ready) begin
            exp_q.push_back(model(x, y));
            n_in++;
        end
    endtask

    // One cycle: drive at the falling edge, score shortly after
    task automatic step(input logic iv, input logic [31:0] ix, input logic [31:0] iy,
                        input logic ordy);
        @(negedge clk);
        in_valid  = iv;
        x         = ix;
        y         = iy;
        out_ready = ordy;
        #1;
        monitor();
    endtask

    task automatic expect_out(input string tag, input logic [34:0] want);
        chk({tag, "_vld"}, 64'(out_valid), 64'(1));
        chk(tag, 64'({d, borrow, ovf, zero}), 64'(want));
    endtask

    // Two back-to-back ops, each checked against a hand-derived constant
    task automatic pair(input string t1, input logic [31:0] x1, input logic [31:0] y1,
                        input logic [34:0] e1,
                        input string t2, input logic [31:0] x2, input logic [31:0] y2,
                        input logic [34:0] e2);
        step(1'b1, x1, y1, 1'b1);
        step(1'b1, x2, y2, 1'b1);
        step(1'b0, 32'd0, 32'd0, 1'b1);
        expect_out(t1, e1);
        step(1'b0, 32'd0, 32'd0, 1'b1);
        expect_out(t2, e2);
    endtask

    // Bounded drain of everything still expected
    task automatic drain(input string tag);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            step(1'b0, 32'd0, 32'd0, 1'b1);
        end
        chk(tag, 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int acc0;
        logic [31:0] rx;
        logic [31:0] ry;
        logic        rv;
        logic        rr;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; x = '0; y = '0;
        #1;
        chk("rst_out", 64'({out_valid, d, borrow, ovf, zero}), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 32'd0, 32'd0, 1'b1);
        chk("rst_ready", 64'(in_ready), 64'(1));

        // Basic latency: 5 - 3
        step(1'b1, 32'd5, 32'd3, 1'b1);
        step(1'b0, 32'd0, 32'd0, 1'b1);
        chk("t1_lat1", 64'(out_valid), 64'(0));
        step(1'b0, 32'd0, 32'd0, 1'b1);
        expect_out("t1", {32'd2, 1'b0, 1'b0, 1'b0});
        drain("t1_drain");

        pair("t2_wrap", 32'd0, 32'd1, {32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0},
             "t2_eq", 32'hDEAD_BEEF, 32'hDEAD_BEEF, {32'd0, 1'b0, 1'b0, 1'b1});
        pair("t3_ovfa", 32'h8000_0000, 32'd1, {32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0},
             "t3_ovfb", 32'h7FFF_FFFF, 32'hFFFF_FFFF, {32'h8000_0000, 1'b1, 1'b1, 1'b0});
        pair("t4_chain", 32'h0204_0000, 32'd1, {32'h0203_FFFF, 1'b0, 1'b0, 1'b0},
             "t4_c18", 32'h0004_0000, 32'd1, {32'h0003_FFFF, 1'b0, 1'b0, 1'b0});
        pair("t4_y0", 32'h1234_5678, 32'd0, {32'h1234_5678, 1'b0, 1'b0, 1'b0},
             "t4_full", 32'd0, 32'hFFFF_FFFF, {32'd1, 1'b1, 1'b0, 1'b0});
        drain("t4_drain");

        // Backpressure: A=100-1, B=0-5, C=7-7 with out_ready low for 6 cycles
        step(1'b1, 32'd100, 32'd1, 1'b0);
        step(1'b1, 32'd0, 32'd5, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'd7, 32'd7, 1'b0);
            chk("t5_stall_rdy", 64'(in_ready), 64'(0));
            expect_out("t5_hold", {32'd99, 1'b0, 1'b0, 1'b0});
        end
        chk("t5_buffered", 64'(exp_q.size()), 64'(2));
        n0 = n_out;
        step(1'b1, 32'd7, 32'd7, 1'b1);
        expect_out("t5_a", {32'd99, 1'b0, 1'b0, 1'b0});
        step(1'b0, 32'd0, 32'd0, 1'b1);
        expect_out("t5_b", {32'hFFFF_FFFB, 1'b1, 1'b0, 1'b0});
        step(1'b0, 32'd0, 32'd0, 1'b1);
        expect_out("t5_c", {32'd0, 1'b0, 1'b0, 1'b1});
        step(1'b0, 32'd0, 32'd0, 1'b1);
        chk("t5_empty", 64'(out_valid), 64'(0));
        chk("t5_count", 64'(n_out - n0), 64'(3));

        // Reset while both stages hold data
        step(1'b1, 32'd50, 32'd20, 1'b0);
        step(1'b1, 32'd60, 32'd30, 1'b0);
        step(1'b0, 32'd0, 32'd0, 1'b0);
        chk("t6_full", 64'({out_valid, in_ready}), 64'(2'b10));
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async", 64'({out_valid, d, borrow, ovf, zero}), 64'(0));
        exp_q.delete();
        step(1'b0, 32'd0, 32'd0, 1'b1);
        rst_n = 1'b1;
        step(1'b1, 32'd10, 32'd4, 1'b1);
        step(1'b0, 32'd0, 32'd0, 1'b1);
        step(1'b0, 32'd0, 32'd0, 1'b1);
        expect_out("t6_after", {32'd6, 1'b0, 1'b0, 1'b0});
        drain("t6_drain");

        // Random stream against the model
        acc0 = n_in;
        for (int c = 0; c < 40000 && (n_in - acc0) < 10000; c++) begin
            rx = $urandom();
            case ($urandom_range(0, 7))
                0:       ry = rx;
                1:       ry = 32'd0;
                2:       ry = rx + 32'd1;
                default: ry = $urandom();
            endcase
            rv = ($urandom_range(0, 9) < 7);
            rr = ($urandom_range(0, 9) < 7);
            step(rv, rx, ry, rr);
        end
        chk("rand_count", 64'((n_in - acc0) >= 10000), 64'(1));
        drain("rand_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
